parity_stream_checker: RTL and testbench

// Parametrised, clocked successor to the board-level 4-bit parity generator/checker.
// - Accepts a stream of DATA_W-bit words, each with a received parity bit, over a valid/ready handshake.
// - For each word: generates the even/odd parity bit and checks the received bit against it.
// - Tracks word and error totals in saturating counters, plus a sticky error flag for board LEDs/HEX.

---
 rtl/parity_stream_checker_if.sv | 26 ++
 rtl/parity_stream_checker.sv | 70 +++++++
 tb/tb_parity_stream_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/parity_stream_checker_if.sv
// Word stream into the parity checker and its registered result stream out.
// The checker connects through the slave modport; the producer/consumer side uses master.
interface parity_stream_checker_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_parity;
   logic              mode_odd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_gen_par;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_parity, mode_odd, out_ready,
      input  in_ready, out_valid, out_data, out_gen_par, out_err
   );

   modport slave (
      input  in_valid, in_data, in_parity, mode_odd, out_ready,
      output in_ready, out_valid, out_data, out_gen_par, out_err
   );
endinterface

// File: rtl/parity_stream_checker.sv
// Per-word parity generator/checker with saturating word/error counters and a sticky error flag.
// Result appears one cycle after acceptance; a one-entry output register accepts a new word whenever empty or being drained.
module parity_stream_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   parity_stream_checker_if.slave s,
   output logic                 err_sticky,
   output logic [CNT_W-1:0]     word_cnt,
   output logic [CNT_W-1:0]     err_cnt
);
   localparam logic             EMPTY   = 1'b0;
   localparam logic             FULL    = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              state;
   logic [DATA_W-1:0] data_q;
   logic              gen_q;
   logic              err_q;
   logic              acc;
   logic              gen_now;
   logic              err_now;

   assign s.in_ready = (state == EMPTY) | s.out_ready;
   assign acc        = s.in_valid & s.in_ready;
   assign gen_now    = (^s.in_data) ^ s.mode_odd;
   assign err_now    = s.in_parity ^ gen_now;

   assign s.out_valid   = (state == FULL);
   assign s.out_data    = data_q;
   assign s.out_gen_par = gen_q;
   assign s.out_err     = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         data_q <= '0;
         gen_q  <= 1'b0;
         err_q  <= 1'b0;
      end else if (acc) begin
         state  <= FULL;
         data_q <= s.in_data;
         gen_q  <= gen_now;
         err_q  <= err_now;
      end else if (s.out_ready) begin
         // Drained without a replacement: fields keep their last values.
         state <= EMPTY;
      end
   end

   // clear wins over a same-cycle increment, so the word accepted alongside it is not counted.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word_cnt   <= '0;
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (acc) begin
         if (word_cnt != CNT_MAX)
            word_cnt <= word_cnt + CNT_ONE;
         if (err_now && (err_cnt != CNT_MAX))
            err_cnt <= err_cnt + CNT_ONE;
         if (err_now)
            err_sticky <= 1'b1;
      end
   end
endmodule

// File: tb/tb_parity_stream_checker.sv
// Randomised bench for parity_stream_checker: a driver keeps a counting reference model and queues
// expected results; an independent monitor compares every presented result against the queue head.
module tb_parity_stream_checker;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              clear = 1'b0;
   logic              err_sticky;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  err_cnt;

   parity_stream_checker_if #(.DATA_W(DATA_W)) bus ();

   parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .s          (bus),
      .err_sticky (err_sticky),
      .word_cnt   (word_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              gen;
      logic              err;
   } res_t;

   res_t exp_q[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   pending = 0;
   int   words   = 0;
   int   errs    = 0;
   int   sticky  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int sat(input int n);
      return (n > CMAX) ? CMAX : n;
   endfunction

   // Parity from the population count of the word, then flipped for odd mode.
   function automatic bit ref_gen(input logic [DATA_W-1:0] d, input bit m);
      return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ m;
   endfunction

   // One clock of stimulus; checks state left by the previous edge, then advances the model.
   task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit p, input bit m,
                        input bit ordy, input bit clr, input bit rst);
      bit gen, err, acc;
      @(posedge clk); #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_parity = p;
      bus.mode_odd  = m;
      bus.out_ready = ordy;
      clear         = clr;
      reset         = rst;
      @(negedge clk); #1;
      chk("in_ready",   int'(bus.in_ready),  int'(pending == 0 || ordy));
      chk("out_valid",  int'(bus.out_valid), int'(pending != 0));
      chk("word_cnt",   int'(word_cnt),      sat(words));
      chk("err_cnt",    int'(err_cnt),       sat(errs));
      chk("err_sticky", int'(err_sticky),    sticky);
      gen = ref_gen(d, m);
      err = p ^ gen;
      acc = v && (pending == 0 || ordy);
      if (rst) begin
         pending = 0; words = 0; errs = 0; sticky = 0;
         exp_q.delete();
      end else begin
         if (pending != 0 && ordy) pending--;
         if (acc) begin
            pending++;
            exp_q.push_back(res_t'{data: d, gen: gen, err: err});
         end
         if (clr) begin
            words = 0; errs = 0; sticky = 0;
         end else if (acc) begin
            words++;
            if (err) begin errs++; sticky = 1; end
         end
      end
   endtask

   // Monitor: a held result must match the queue head every cycle; it is retired when consumed.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               chk("out_data",    int'(bus.out_data),    int'(exp_q[0].data));
               chk("out_gen_par", int'(bus.out_gen_par), int'(exp_q[0].gen));
               chk("out_err",     int'(bus.out_err),     int'(exp_q[0].err));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] d;
      bit m;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_parity = 1'b0;
      bus.mode_odd  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      cycle(0, 8'h00, 0, 0, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0, 0, 0);
      chk("reset_out_data", int'(bus.out_data),    0);
      chk("reset_gen_par",  int'(bus.out_gen_par), 0);
      chk("reset_out_err",  int'(bus.out_err),     0);

      cycle(1, 8'hA5, 0, 0, 1, 0, 0);
      cycle(1, 8'h01, 1, 1, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0, 0);
      chk("odd_err_sticky", int'(err_sticky), 1);
      chk("odd_err_cnt",    int'(err_cnt),    1);

      // Stall: word held while downstream is not ready.
      cycle(1, 8'h3C, 0, 0, 0, 0, 0);
      repeat (3) cycle(1, 8'hC3, 1, 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0, 0);

      // clear alongside an errored word: not counted, result still flags the error.
      cycle(1, 8'h07, 0, 0, 1, 1, 0);
      cycle(0, 8'h00, 0, 0, 1, 0, 0);
      chk("clear_word_cnt", int'(word_cnt),   0);
      chk("clear_sticky",   int'(err_sticky), 0);

      // Reset with a stalled result pending.
      cycle(1, 8'hF0, 1, 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0, 0, 0);
      chk("rst_pend_valid", int'(bus.out_valid), 0);
      chk("rst_pend_ready", int'(bus.in_ready),  1);
      chk("rst_pend_data",  int'(bus.out_data),  0);

      // Saturation: 300 words, all with wrong parity.
      for (int i = 0; i < 300; i++) begin
         d = DATA_W'($urandom);
         m = 1'($urandom);
         cycle(1, d, ~ref_gen(d, m), m, 1, 0, 0);
      end
      cycle(0, 8'h00, 0, 0, 1, 0, 0);
      chk("sat_word_cnt", int'(word_cnt), CMAX);
      chk("sat_err_cnt",  int'(err_cnt),  CMAX);

      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 199) == 0));
      end
      repeat (4) cycle(0, 8'h00, 0, 0, 1, 0, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
